// File: rtl/instr_encoder.sv
// RV32I instruction encoder: validates symbolic commands and packs legal ones into
// 32-bit words queued in a DEPTH-entry output FIFO; rejected commands pulse err.
module instr_encoder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [4:0]               op,
    input  logic [4:0]               rd,
    input  logic [4:0]               rs1,
    input  logic [4:0]               rs2,
    input  logic [31:0]              imm,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              iword,
    output logic                     err,
    output logic [7:0]               err_count,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FullLvl = (AW + 1)'(DEPTH);

    logic [31:0]   word;
    logic          legal;
    logic [2:0]    f3;
    logic          alt;
    logic          imm12_ok;
    logic          imm13_ok;

    logic [31:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          err_q;
    logic [7:0]    err_count_q;
    logic          accept, push, pop;

    // Sign-extension checks: upper bits must all equal the sign bit of the field.
    assign imm12_ok = (&imm[31:11]) | ~(|imm[31:11]);
    assign imm13_ok = (&imm[31:12]) | ~(|imm[31:12]);

    always_comb begin
        word  = '0;
        legal = 1'b0;
        f3    = 3'b000;
        alt   = 1'b0;
        if (op <= 5'd7) begin
            case (op[2:0])
                3'd0, 3'd1: f3 = 3'b000;
                3'd2:       f3 = 3'b001;
                3'd3:       f3 = 3'b100;
                3'd4, 3'd5: f3 = 3'b101;
                3'd6:       f3 = 3'b110;
                default:    f3 = 3'b111;
            endcase
            alt   = (op == 5'd1) || (op == 5'd5);
            word  = {1'b0, alt, 5'b0, rs2, rs1, f3, rd, 7'b0110011};
            legal = 1'b1;
        end else if (op <= 5'd11) begin
            case (op)
                5'd8:    f3 = 3'b000;
                5'd9:    f3 = 3'b100;
                5'd10:   f3 = 3'b110;
                default: f3 = 3'b111;
            endcase
            word  = {imm[11:0], rs1, f3, rd, 7'b0010011};
            legal = imm12_ok;
        end else if (op <= 5'd14) begin
            f3    = (op == 5'd12) ? 3'b001 : 3'b101;
            alt   = (op == 5'd14);
            word  = {1'b0, alt, 5'b0, imm[4:0], rs1, f3, rd, 7'b0010011};
            legal = ~(|imm[31:5]);
        end else if (op == 5'd15) begin
            word  = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
            legal = imm12_ok;
        end else if (op == 5'd16) begin
            word  = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
            legal = imm12_ok;
        end else if (op <= 5'd22) begin
            case (op)
                5'd17:   f3 = 3'b000;
                5'd18:   f3 = 3'b001;
                5'd19:   f3 = 3'b100;
                5'd20:   f3 = 3'b101;
                5'd21:   f3 = 3'b110;
                default: f3 = 3'b111;
            endcase
            word  = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
            legal = ~imm[0] & imm13_ok;
        end
    end

    assign in_ready  = (level_q != FullLvl);
    assign out_valid = (level_q != '0);
    assign accept    = in_valid & in_ready;
    assign push      = accept & legal;
    assign pop       = out_valid & out_ready;

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            err_q       <= 1'b0;
            err_count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= word;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
            err_q   <= accept & ~legal;
            if (accept && !legal && err_count_q != 8'hFF) begin
                err_count_q <= err_count_q + 8'd1;
            end
        end
    end

    // Empty FIFO shows 0 rather than a stale entry.
    assign iword     = out_valid ? mem_q[rd_ptr_q] : 32'h0;
    assign err       = err_q;
    assign err_count = err_count_q;
    assign level     = level_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: expected words queue in a scoreboard at drive time
// and are compared as the DUT pops them.
module tb_instr_encoder;
    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  op, rd, rs1, rs2;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] iword;
    logic        err;
    logic [7:0]  err_count;
    logic [$clog2(DEPTH):0] level;

    logic [31:0] sb[$];
    int n_total = 0;
    int n_pass  = 0;

    instr_encoder #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rd        (rd),
        .rs1       (rs1),
        .rs2       (rs2),
        .imm       (imm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .iword     (iword),
        .err       (err),
        .err_count (err_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) check("iword_pop", iword, sb.pop_front());
        end
    end

    task automatic send(input logic [4:0] o, input logic [4:0] r, input logic [4:0] a,
                        input logic [4:0] b, input logic [31:0] im, input bit ok,
                        input logic [31:0] w, output int waits);
        op = o; rd = r; rs1 = a; rs2 = b; imm = im; in_valid = 1'b1;
        waits = 0;
        while (!in_ready && waits < 20) begin
            @(posedge clk); #1;
            waits++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        if (ok) sb.push_back(w);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while ((out_valid || sb.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drained_out_valid", 32'(out_valid), 32'd0);
        check("drained_sb", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        #12;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_iword", iword, 32'h0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        // R-type with 1-cycle latency, no fall-through beyond one edge
        send(5'd0, 5'd18, 5'd10, 5'd31, 32'd0, 1'b1, 32'h01F50933, w);
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_iword", iword, 32'h01F50933);
        check("add_err", 32'(err), 32'd0);
        send(5'd1, 5'd18, 5'd10, 5'd31, 32'd0, 1'b1, 32'h41F50933, w);
        check("sub_level", 32'(level), 32'd2);
        check("sub_head_stable", iword, 32'h01F50933);
        drain();

        // Shifts
        send(5'd14, 5'd18, 5'd10, 5'd0, 32'd31, 1'b1, 32'h41F55913, w);
        check("srai_err", 32'(err), 32'd0);
        send(5'd12, 5'd18, 5'd10, 5'd0, 32'd32, 1'b0, 32'h0, w);
        check("slli32_err", 32'(err), 32'd1);
        check("slli32_cnt", 32'(err_count), 32'd1);
        check("slli32_nopush", 32'(level), 32'd0);
        @(posedge clk); #1;
        check("slli32_err_pulse", 32'(err), 32'd0);

        // Loads, stores, I-ALU
        send(5'd15, 5'd10, 5'd21, 5'd0, 32'hFFFFFAAA, 1'b1, 32'hAAAAA503, w);
        send(5'd8, 5'd1, 5'd2, 5'd0, 32'd2048, 1'b0, 32'h0, w);
        check("addi2048_err", 32'(err), 32'd1);
        check("addi2048_cnt", 32'(err_count), 32'd2);
        send(5'd8, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF10093, w);
        check("addi_m1_err", 32'(err), 32'd0);
        send(5'd16, 5'd0, 5'd2, 5'd3, 32'd8, 1'b1, 32'h00312423, w);
        drain();

        // Branches and illegal opcodes; back-to-back rejections hold err
        send(5'd17, 5'd0, 5'd19, 5'd10, 32'd16, 1'b1, 32'h00A98863, w);
        send(5'd18, 5'd0, 5'd19, 5'd10, 32'd15, 1'b0, 32'h0, w);
        check("bne_odd_err", 32'(err), 32'd1);
        send(5'd25, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0, 32'h0, w);
        check("op25_err_held", 32'(err), 32'd1);
        send(5'd17, 5'd0, 5'd0, 5'd0, 32'd4096, 1'b0, 32'h0, w);
        check("beq4096_cnt", 32'(err_count), 32'd5);
        send(5'd17, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b1, 32'h7E000FE3, w);
        check("beq4094_err", 32'(err), 32'd0);
        drain();

        // Fill to DEPTH with out_ready low, then drain while a 5th waits
        out_ready = 1'b0;
        send(5'd0, 5'd18, 5'd10, 5'd31, 32'd0, 1'b1, 32'h01F50933, w);
        send(5'd1, 5'd18, 5'd10, 5'd31, 32'd0, 1'b1, 32'h41F50933, w);
        send(5'd8, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFF, 1'b1, 32'hFFF10093, w);
        send(5'd16, 5'd0, 5'd2, 5'd3, 32'd8, 1'b1, 32'h00312423, w);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_level", 32'(level), 32'd4);
        check("full_head", iword, 32'h01F50933);
        out_ready = 1'b1;
        send(5'd20, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, 32'hFE20DEE3, w);
        check("fifth_wait_cycles", 32'(w), 32'd1);
        check("fifth_level", 32'(level), 32'd3);
        drain();

        // Asynchronous reset mid-operation discards buffered words
        out_ready = 1'b0;
        send(5'd0, 5'd18, 5'd10, 5'd31, 32'd0, 1'b1, 32'h01F50933, w);
        send(5'd1, 5'd18, 5'd10, 5'd31, 32'd0, 1'b1, 32'h41F50933, w);
        send(5'd15, 5'd10, 5'd21, 5'd0, 32'hFFFFFAAA, 1'b1, 32'hAAAAA503, w);
        check("pre_rst_level", 32'(level), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_level", 32'(level), 32'd0);
        check("arst_err_count", 32'(err_count), 32'd0);
        check("arst_iword", iword, 32'h0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        sb.delete();
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        send(5'd17, 5'd0, 5'd19, 5'd10, 32'd16, 1'b1, 32'h00A98863, w);
        check("post_rst_iword", iword, 32'h00A98863);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

RV32I instruction encoder: the inverse of the control-unit decode path. It accepts symbolic commands (mnemonic code, register indices, immediate) over a valid/ready handshake, validates them, and packs each into a 32-bit instruction word. Legal words are buffered in an output FIFO for the instruction-memory loader. Illegal or out-of-range commands are dropped and flagged.

## Interface

- DEPTH, 4: output FIFO entries; power of two, ≥2.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  command present.
- in_ready  out  1  command accepted when in_valid & in_ready at a clk edge.
- op  in  5  mnemonic:
  - R-type: 0 ADD, 1 SUB, 2 SLL, 3 XOR, 4 SRL, 5 SRA, 6 OR, 7 AND.
  - I-type and shifts: 8 ADDI, 9 XORI, 10 ORI, 11 ANDI, 12 SLLI, 13 SRLI, 14 SRAI.
  - Memory: 15 LW, 16 SW.
  - Branch: 17 BEQ, 18 BNE, 19 BLT, 20 BGE, 21 BLTU, 22 BGEU.
  - 23–31 illegal.
- rd, rs1, rs2  in  5 each  register indices; fields unused by the format are ignored.
- imm  in  32  signed immediate, branch byte offset, or shift amount.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer takes iword when out_valid & out_ready.
- iword  out  32  FIFO head word.
- err  out  1  one-cycle pulse: the previous accepted command was rejected.
- err_count  out  8  saturating count of rejected commands.
- level  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation

**Encoding** (opcodes and funct fields per RV32I):
- R-type (0–7): funct7|rs2|rs1|funct3|rd|0110011.
  - funct7 = 0100000 for SUB and SRA, else 0000000.
  - funct3: ADD/SUB 000, SLL 001, XOR 100, SRL/SRA 101, OR 110, AND 111.
- I-ALU (8–11): imm[11:0]|rs1|funct3|rd|0010011.
  - funct3: ADDI 000, XORI 100, ORI 110, ANDI 111.
- Shifts (12–14): funct7|imm[4:0]|rs1|funct3|rd|0010011.
  - funct3: SLLI 001, SRLI/SRAI 101.
  - funct7 = 0100000 for SRAI, else 0000000.
- LW: imm[11:0]|rs1|010|rd|0000011.
- SW: imm[11:5]|rs2|rs1|010|imm[4:0]|0100011.
- Branch: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|1100011.
  - funct3: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111.

**Rejection rules** (command is dropped, err raised):
- op ≥ 23.
- I-ALU, LW, SW: imm outside −2048..2047, i.e. imm[31:11] is not all-equal.
- Shifts: imm outside 0..31.
- Branch: imm[0] = 1, or imm outside −4096..4094.

**FIFO**
- DEPTH-entry circular buffer with rd_ptr/wr_ptr wrapping modulo DEPTH.
- Legal accepted command: encoded word is written at the accepting edge.
- Rejected command: consumes the handshake, writes nothing.
- in_ready = (level != DEPTH). Not combinationally dependent on out_ready.
- Pop on out_valid & out_ready. Simultaneous push and pop when 0 < level < DEPTH leaves level unchanged.
- Push when empty: the word is not visible until the next cycle; there is no fall-through.

**Error reporting**
- err is registered, high for exactly the cycle after a rejecting accept.
- err_count increments on each rejection and saturates at 255.

## Timing

- Reset (async assert, sync release): pointers 0, level 0, in_ready 1, out_valid 0, iword 0, err 0, err_count 0.
- Reset mid-operation discards all buffered words immediately.
- Latency: command accepted at edge N → iword valid, out_valid = 1 from edge N (observable in cycle N+1).
- Throughput: one command per cycle while not full; one word per cycle drained.
- Full (level = DEPTH): in_ready = 0. A pop in that cycle raises in_ready from the following cycle.
- iword holds stable while out_valid & !out_ready.
- With out_ready held low, iword is undefined-free: it shows the head word, or 0 when empty.
- Back-to-back rejections hold err high continuously.

## Test plan

- ADD rd=18 rs1=10 rs2=31, then SUB with the same fields → iword 0x01F50933, then 0x41F50933; latency 1 cycle; err stays 0.
- SRAI rd=18 rs1=10 imm=31 → 0x41F55913. Then SLLI with imm=32 → no push, err pulses 1 cycle, err_count=1.
- LW rd=10 rs1=21 imm=0xFFFFFAAA → 0xAAAAA503. Then ADDI with imm=2048 → rejected, err_count increments.
- BEQ rs1=19 rs2=10 imm=16 → 0x00A98863. BNE with imm=15 (odd) → rejected. op=25 → rejected.
- Hold out_ready=0 and issue 5 legal commands with DEPTH=4:
  - after 4 accepts, in_ready=0 and level=4;
  - assert out_ready: words drain in order, and the 5th command is accepted the cycle after the first pop.
- Assert rst with level=3 → out_valid=0, level=0, err_count=0 asynchronously; after release, the next word is encoded normally.
